serializer_p: RTL and testbench
===============================

# serializer_p

Parametrised successor to the team's 16-bit serializer: accepts a parallel word plus a valid-length field and shifts it out one bit per transfer on a serial stream. The block adds:
- generic data width;
- a selectable bit order;
- a last-bit marker;
- downstream backpressure.

It sits between a parallel word source and a bit-serial line encoder/transmitter. Each word is captured once at acceptance, so it is immune to input changes mid-packet.

## Interface
Parameters:
- DATA_W, 16, parallel word width; must be a power of two, ≥ 4.
- MOD_W, $clog2(DATA_W), width of data_mod_i; derived, not overridden.
- MIN_MOD, 3, smallest non-zero length accepted; shorter non-zero lengths are dropped.
- MSB_FIRST, 1, bit order: 1 = MSB first, 0 = LSB first.

Ports:
- clk_i, in, 1, single clock; all logic on the rising edge.
- srst_i, in, 1, reset, synchronous and active-high.
- data_i, in, DATA_W, parallel word.
- data_mod_i, in, MOD_W, number of valid bits; 0 means DATA_W.
- data_val_i, in, 1, data_i/data_mod_i valid this cycle.
- ser_data_ready_i, in, 1, downstream can take the current serial bit.
- ser_data_o, out, 1, serial bit.
- ser_data_val_o, out, 1, ser_data_o valid.
- ser_data_last_o, out, 1, current bit is the last of the packet.
- busy_o, out, 1, packet in flight; input is not accepted.

## Operation
- Two states: IDLE and SHIFT. All outputs are registered.
- **Length:** len = (data_mod_i == 0) ? DATA_W : data_mod_i.
- **Accept:** occurs in IDLE when data_val_i = 1 and the length is legal (data_mod_i == 0 or data_mod_i ≥ MIN_MOD). On accept:
  - data_i is captured into the shift buffer;
  - the remaining-bit counter is set to len;
  - the state moves to SHIFT.
- **Illegal length:** when 0 < data_mod_i < MIN_MOD, the word is silently dropped. The state stays IDLE, no output is produced and busy_o stays 0.
- **Input while busy:** data_val_i in SHIFT is ignored and the word is lost. Upstream must gate on busy_o.
- **Bit order, MSB_FIRST = 1:** bits are sent as data_i[DATA_W-1] down to data_i[DATA_W-len].
- **Bit order, MSB_FIRST = 0:** bits are sent as data_i[0] up to data_i[len-1].
- **In SHIFT:** ser_data_val_o = 1 and busy_o = 1.
  - A transfer happens on each cycle where ser_data_val_o and ser_data_ready_i are both 1.
  - Each transfer presents the next bit on the following cycle.
  - When ready is low, ser_data_o, ser_data_val_o and ser_data_last_o hold their values.
- **Last bit:** ser_data_last_o = 1 exactly while the final bit of the packet is presented. The transfer of that bit returns the block to IDLE, with ser_data_val_o, ser_data_last_o and busy_o all 0 on the next cycle.
- **Counter:** MOD_W+1 bits wide so it can hold len = DATA_W. It decrements per transfer; the last bit is presented when the counter equals 1.
- **Reset:** srst_i overrides everything, including mid-packet. The state goes to IDLE, the buffer and counter clear, and the packet in flight is discarded with no last marker.
- **Reset values:** ser_data_o = 0, ser_data_val_o = 0, ser_data_last_o = 0, busy_o = 0.
- **Outside SHIFT:** ser_data_o is driven 0.

## Timing
- **Accept to first bit:** accept at edge N; the first bit is valid after edge N, with busy_o = 1 in the same cycle.
- **Packet duration with ready held high:** len cycles of ser_data_val_o = 1, then busy_o = 0 on the cycle after the last transfer.
- **Back-to-back packets:** at least one IDLE cycle separates packets, since busy_o is 0 for that cycle. The minimum packet period is len + 1 cycles.
- **Acceptance timing:** a word presented in the same cycle busy_o falls to 0 is accepted, because the block is already IDLE that cycle.
- **Backpressure:** each ready-low cycle in SHIFT adds exactly one cycle to the packet.
- **Length 1:** not reachable when MIN_MOD ≥ 2. If MIN_MOD = 1, a single bit is sent with val = 1 and last = 1 together for one transfer.

## Test plan
- **Full word, MSB first:** DATA_W = 16, MSB_FIRST = 1, data_i = 16'hA5C3, data_mod_i = 0, ready held 1 → 16 bits 1010_0101_1100_0011 on consecutive cycles; last = 1 on bit 16 only; busy_o = 0 the following cycle.
- **Partial, LSB first:** MSB_FIRST = 0, data_i = 16'h00F2, data_mod_i = 5 → bits 0,1,0,0,1; last on bit 5; data_i changed mid-packet has no effect.
- **Illegal length:** data_mod_i = 1 and then 2, with data_val_i = 1 → no ser_data_val_o, busy_o stays 0. A following data_mod_i = 3 word is accepted and sends 3 bits.
- **Backpressure:** data_mod_i = 4; ready low for 3 cycles after bit 2 → bit 2 held stable for those 3 cycles; total of 7 valid cycles; the bit sequence is unchanged.
- **Busy drop and back-to-back:** data_val_i asserted during SHIFT → that word never appears. data_val_i asserted on the first IDLE cycle → the next packet starts the cycle after.
- **Reset mid-packet:** srst_i pulsed at bit 6 of 16 → all outputs 0 on the next cycle. After reset, a new word serializes correctly from its first bit.

Source files
------------

// File: rtl/serializer_p.sv
`default_nettype none
// ============================================================================
// Module   : serializer_p
// Purpose  : Parallel-to-serial converter with selectable bit order, a
//            variable packet length, a last-bit marker and downstream
//            ready/valid backpressure. The word is captured once at
//            acceptance, so later changes on data_i have no effect.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module serializer_p #(
  parameter int DATA_W    = 16,
  parameter int MOD_W     = $clog2(DATA_W),
  parameter int MIN_MOD   = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  input  logic              ser_data_ready_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_data_last_o,
  output logic              busy_o
);

  // Counter constants; the counter is one bit wider than data_mod_i so it
  // can hold a full-word length.
  localparam logic [MOD_W:0] CNT_ONE  = (MOD_W+1)'(1);
  localparam logic [MOD_W:0] CNT_TWO  = (MOD_W+1)'(2);
  localparam logic [MOD_W:0] CNT_FULL = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] MIN_LEN  = (MOD_W+1)'(MIN_MOD);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Shift register holds the bits still to be presented after the current
  // one; the current bit lives in ser_data_o itself.
  logic [DATA_W-1:0] shift_reg, shift_reg_nxt;
  logic [MOD_W:0]    cnt, cnt_nxt;
  logic              ser_nxt, val_nxt, last_nxt, busy_nxt;

  logic [MOD_W:0]    len;
  logic              len_legal;
  logic              xfer;

  // Bit-order specific taps: the first bit of a fresh word, the word with
  // that bit removed, and the same two views of the stored shift register.
  logic              data_head;
  logic [DATA_W-1:0] data_rest;
  logic              reg_head;
  logic [DATA_W-1:0] reg_rest;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign data_head = data_i[DATA_W-1];
      assign data_rest = {data_i[DATA_W-2:0], 1'b0};
      assign reg_head  = shift_reg[DATA_W-1];
      assign reg_rest  = {shift_reg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign data_head = data_i[0];
      assign data_rest = {1'b0, data_i[DATA_W-1:1]};
      assign reg_head  = shift_reg[0];
      assign reg_rest  = {1'b0, shift_reg[DATA_W-1:1]};
    end
  endgenerate

  // A zero length field means a full word; short non-zero lengths are illegal.
  assign len       = (data_mod_i == '0) ? CNT_FULL : {1'b0, data_mod_i};
  assign len_legal = (data_mod_i == '0) || ({1'b0, data_mod_i} >= MIN_LEN);
  assign xfer      = ser_data_val_o && ser_data_ready_i;

  // Next-state and next-output decode; every target holds by default.
  always_comb begin
    state_nxt     = state;
    shift_reg_nxt = shift_reg;
    cnt_nxt       = cnt;
    ser_nxt       = ser_data_o;
    val_nxt       = ser_data_val_o;
    last_nxt      = ser_data_last_o;
    busy_nxt      = busy_o;

    unique case (state)
      ST_IDLE: begin
        // Outputs are already zero in IDLE; only a legal valid word moves us.
        if (data_val_i && len_legal) begin
          state_nxt     = ST_SHIFT;
          shift_reg_nxt = data_rest;
          cnt_nxt       = len;
          ser_nxt       = data_head;
          val_nxt       = 1'b1;
          busy_nxt      = 1'b1;
          last_nxt      = (len == CNT_ONE);
        end
      end

      ST_SHIFT: begin
        // New words are ignored here; only a completed transfer advances.
        if (xfer) begin
          if (cnt == CNT_ONE) begin
            state_nxt     = ST_IDLE;
            shift_reg_nxt = '0;
            cnt_nxt       = '0;
            ser_nxt       = 1'b0;
            val_nxt       = 1'b0;
            last_nxt      = 1'b0;
            busy_nxt      = 1'b0;
          end else begin
            shift_reg_nxt = reg_rest;
            cnt_nxt       = cnt - CNT_ONE;
            ser_nxt       = reg_head;
            last_nxt      = (cnt == CNT_TWO);
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset discards any packet.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state           <= ST_IDLE;
      shift_reg       <= '0;
      cnt             <= '0;
      ser_data_o      <= 1'b0;
      ser_data_val_o  <= 1'b0;
      ser_data_last_o <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state           <= state_nxt;
      shift_reg       <= shift_reg_nxt;
      cnt             <= cnt_nxt;
      ser_data_o      <= ser_nxt;
      ser_data_val_o  <= val_nxt;
      ser_data_last_o <= last_nxt;
      busy_o          <= busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serializer_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_serializer_p
// Purpose  : Bench for serializer_p. Two instances (MSB-first and LSB-first)
//            share one stimulus; a queue-based packet model predicts every
//            output cycle, and literal expectations pin the collected streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serializer_p;

  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] data;
  logic [MW-1:0] dmod;
  logic          dval;
  logic          ready;

  logic ser_m, val_m, last_m, busy_m;
  logic ser_l, val_l, last_l, busy_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serializer_p #(.DATA_W(DW), .MIN_MOD(3), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_mod_i(dmod),
    .data_val_i(dval), .ser_data_ready_i(ready), .ser_data_o(ser_m),
    .ser_data_val_o(val_m), .ser_data_last_o(last_m), .busy_o(busy_m));

  serializer_p #(.DATA_W(DW), .MIN_MOD(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_mod_i(dmod),
    .data_val_i(dval), .ser_data_ready_i(ready), .ser_data_o(ser_l),
    .ser_data_val_o(val_l), .ser_data_last_o(last_l), .busy_o(busy_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per instance, a queue of the bits still owed for the current
  // packet; the head is the bit on the line, an empty queue means idle.
  bit mq[2][$];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (srst) begin
        mq[k].delete();
      end else if (mq[k].size() == 0) begin
        if (dval && (dmod == 0 || dmod >= 3)) begin
          int n;
          n = (dmod == 0) ? DW : int'(dmod);
          for (int i = 0; i < n; i++)
            mq[k].push_back(k == 0 ? data[DW-1-i] : data[i]);
        end
      end else if (ready) begin
        void'(mq[k].pop_front());
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic e_ser, e_act, e_last;
      e_act  = (mq[k].size() != 0);
      e_ser  = e_act ? mq[k][0] : 1'b0;
      e_last = (mq[k].size() == 1);
      if (k == 0) begin
        chk("msb_ser",  32'(ser_m),  32'(e_ser));
        chk("msb_val",  32'(val_m),  32'(e_act));
        chk("msb_last", 32'(last_m), 32'(e_last));
        chk("msb_busy", 32'(busy_m), 32'(e_act));
      end else begin
        chk("lsb_ser",  32'(ser_l),  32'(e_ser));
        chk("lsb_val",  32'(val_l),  32'(e_act));
        chk("lsb_last", 32'(last_l), 32'(e_last));
        chk("lsb_busy", 32'(busy_l), 32'(e_act));
      end
    end
  end

  // Collect transferred bits and valid-cycle counts for literal checks.
  bit ms[$];
  bit ls[$];
  int vcnt_m;

  always @(posedge clk) begin
    if (!srst) begin
      if (val_m) vcnt_m++;
      if (val_m && ready) ms.push_back(ser_m);
      if (val_l && ready) ls.push_back(ser_l);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_streams();
    ms.delete();
    ls.delete();
    vcnt_m = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy_m || busy_l) && n < 64) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, 32'(busy_m | busy_l), 32'd0);
  endtask

  // First transferred bit lands in the MSB of the result.
  function automatic logic [31:0] pack_msb(input bit s[$]);
    logic [31:0] w;
    w = '0;
    foreach (s[i]) w = {w[30:0], s[i]};
    return w;
  endfunction

  // First transferred bit lands in bit 0 of the result.
  function automatic logic [31:0] pack_lsb(input bit s[$]);
    logic [31:0] w;
    w = '0;
    foreach (s[i]) w[i] = s[i];
    return w;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic [MW-1:0] m);
    data = d;
    dmod = m;
    dval = 1'b1;
    tick();
    dval = 1'b0;
  endtask

  initial begin
    srst   = 1'b1;
    data   = '0;
    dmod   = '0;
    dval   = 1'b0;
    ready  = 1'b1;
    vcnt_m = 0;
    tick();
    tick();
    chk("reset_outputs", {28'd0, ser_m, val_m, last_m, busy_m}, 32'd0);
    srst = 1'b0;
    tick();

    // Full 16-bit word, both bit orders.
    clear_streams();
    send(16'hA5C3, 4'd0);
    wait_idle("full");
    chk("full_msb_len",  32'(ms.size()), 32'd16);
    chk("full_msb_bits", pack_msb(ms),   32'h0000_A5C3);
    chk("full_lsb_bits", pack_lsb(ls),   32'h0000_A5C3);
    chk("full_valcnt",   32'(vcnt_m),    32'd16);

    // Partial 5-bit word; data_i changes mid-packet.
    clear_streams();
    send(16'h00F2, 4'd5);
    data = 16'hFFFF;
    wait_idle("part");
    chk("part_lsb_len",  32'(ls.size()), 32'd5);
    chk("part_lsb_bits", pack_lsb(ls),   32'h12);
    chk("part_msb_bits", pack_msb(ms),   32'h00);

    // Illegal lengths 1 and 2 are dropped, length 3 is accepted.
    clear_streams();
    data = 16'hA005;
    dval = 1'b1;
    dmod = 4'd1;
    tick();
    chk("illegal1_busy", 32'(busy_m | busy_l | val_m | val_l), 32'd0);
    dmod = 4'd2;
    tick();
    chk("illegal2_busy", 32'(busy_m | busy_l | val_m | val_l), 32'd0);
    dval = 1'b0;
    tick();
    send(16'hA005, 4'd3);
    wait_idle("len3");
    chk("len3_msb_bits", pack_msb(ms), 32'h5);
    chk("len3_lsb_len",  32'(ls.size()), 32'd3);

    // Backpressure: bit 2 held for three extra cycles.
    clear_streams();
    send(16'hC00A, 4'd4);
    tick();
    ready = 1'b0;
    tick();
    tick();
    tick();
    ready = 1'b1;
    wait_idle("bp");
    chk("bp_valcnt",   32'(vcnt_m),    32'd7);
    chk("bp_msb_bits", pack_msb(ms),   32'hC);
    chk("bp_lsb_bits", pack_lsb(ls),   32'hA);

    // Word offered while busy is lost; word offered on the first idle cycle
    // is accepted at the next edge.
    clear_streams();
    send(16'h8000, 4'd4);
    data = 16'hFFFF;
    dmod = 4'd0;
    dval = 1'b1;
    wait_idle("b2b_first");
    data = 16'h6005;
    dmod = 4'd3;
    tick();
    dval = 1'b0;
    chk("b2b_accept", 32'(busy_m), 32'd1);
    wait_idle("b2b_second");
    chk("b2b_msb_bits", pack_msb(ms), 32'h43);
    chk("b2b_lsb_bits", pack_lsb(ls), 32'h50);

    // Reset while bit 6 of 16 is on the line, then a fresh word.
    send(16'hFFFF, 4'd0);
    for (int i = 0; i < 5; i++) tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("rst_mid_outputs", {28'd0, ser_m, val_m, last_m, busy_m}, 32'd0);
    clear_streams();
    send(16'h1234, 4'd0);
    wait_idle("post_rst");
    chk("post_rst_msb", pack_msb(ms), 32'h1234);
    chk("post_rst_lsb", pack_lsb(ls), 32'h1234);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
